// File: rtl/pcpi_nibble_sequencer_pkg.sv
// Shared types and widths for the PCPI nibble sequencer.
//   seq_state_t : controller state (LOAD, ISSUE, DRAIN)
//   NIB_W/WORD_W/NIBS/CNT_W/TCNT_W : datapath and counter widths
package pcpi_seq_pkg;

    localparam int unsigned NIB_W  = 4;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned NIBS   = 8;
    localparam int unsigned CNT_W  = 3;
    // Sized for the largest legal TIMEOUT_CYCLES (255).
    localparam int unsigned TCNT_W = 8;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pcpi_nibble_sequencer_if.sv
// PCPI coprocessor bus between the sequencer (master) and the coprocessor (slave).
//   pcpi_valid/pcpi_insn : instruction request from the sequencer
//   pcpi_wr/pcpi_ready/pcpi_wait/pcpi_rd : coprocessor response
interface pcpi_nibble_sequencer_if;
    import pcpi_seq_pkg::*;

    logic              pcpi_valid;
    logic [WORD_W-1:0] pcpi_insn;
    logic              pcpi_wr;
    logic              pcpi_ready;
    logic              pcpi_wait;
    logic [WORD_W-1:0] pcpi_rd;

    modport master (
        output pcpi_valid,
        output pcpi_insn,
        input  pcpi_wr,
        input  pcpi_ready,
        input  pcpi_wait,
        input  pcpi_rd
    );

    modport slave (
        input  pcpi_valid,
        input  pcpi_insn,
        output pcpi_wr,
        output pcpi_ready,
        output pcpi_wait,
        output pcpi_rd
    );

endinterface

// File: rtl/pcpi_nibble_sequencer.sv
// Sequences the shared PCPI coprocessor from a 4-bit pin port: assembles a
// 32-bit instruction from eight nibbles, issues it with a held pcpi_valid and
// a no-wait timeout, then streams any written-back result out as eight nibbles.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous abort back to LOAD
//   nib_valid/nib_data  : instruction nibble input (LSB nibble first)
//   nib_ready           : high in LOAD (state decode)
//   res_valid/res_nib   : result nibble output (state decode), res_ack consumes
//   bus                 : PCPI master port
//   busy                : state is not LOAD
//   done                : registered one-cycle completion pulse
//   err                 : registered sticky timeout flag
module pcpi_nibble_sequencer
    import pcpi_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 nib_valid,
    input  logic [NIB_W-1:0]     nib_data,
    output logic                 nib_ready,
    output logic                 res_valid,
    output logic [NIB_W-1:0]     res_nib,
    input  logic                 res_ack,
    pcpi_nibble_sequencer_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam logic [CNT_W-1:0]  LAST_NIB = CNT_W'(NIBS - 1);
    localparam logic [TCNT_W-1:0] TMO_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   rcnt_q, rcnt_d;
    logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
    logic               wait_seen_q, wait_seen_d;
    logic [WORD_W-1:0]  insn_q, insn_d;
    logic [WORD_W-1:0]  rd_q, rd_d;
    logic               pcpi_valid_q, pcpi_valid_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOAD;
            cnt_q        <= '0;
            rcnt_q       <= '0;
            tcnt_q       <= '0;
            wait_seen_q  <= 1'b0;
            insn_q       <= '0;
            rd_q         <= '0;
            pcpi_valid_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rcnt_q       <= rcnt_d;
            tcnt_q       <= tcnt_d;
            wait_seen_q  <= wait_seen_d;
            insn_q       <= insn_d;
            rd_q         <= rd_d;
            pcpi_valid_q <= pcpi_valid_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rcnt_d      = rcnt_q;
        tcnt_d      = tcnt_q;
        wait_seen_d = wait_seen_q;
        insn_d      = insn_q;
        rd_d        = rd_q;
        done_d      = 1'b0;
        err_d       = err_q;

        if (flush) begin
            state_d     = LOAD;
            cnt_d       = '0;
            rcnt_d      = '0;
            tcnt_d      = '0;
            wait_seen_d = 1'b0;
            err_d       = 1'b0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (nib_valid) begin
                        // Nibble index times four, as a bit offset.
                        insn_d[{cnt_q, 2'b00} +: NIB_W] = nib_data;
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == '0) begin
                            err_d = 1'b0;
                        end
                        if (cnt_q == LAST_NIB) begin
                            state_d     = ISSUE;
                            tcnt_d      = '0;
                            wait_seen_d = 1'b0;
                        end
                    end
                end

                ISSUE: begin
                    tcnt_d = tcnt_q + 8'd1;
                    if (bus.pcpi_wait) begin
                        wait_seen_d = 1'b1;
                    end
                    // Ready wins over a coincident timeout.
                    if (bus.pcpi_ready) begin
                        tcnt_d      = '0;
                        wait_seen_d = 1'b0;
                        if (bus.pcpi_wr) begin
                            rd_d    = bus.pcpi_rd;
                            rcnt_d  = '0;
                            state_d = DRAIN;
                        end else begin
                            state_d = LOAD;
                            done_d  = 1'b1;
                        end
                    end else if (!wait_seen_q && !bus.pcpi_wait && tcnt_q == TMO_LAST) begin
                        tcnt_d  = '0;
                        state_d = LOAD;
                        err_d   = 1'b1;
                    end
                end

                DRAIN: begin
                    if (res_ack) begin
                        rcnt_d = rcnt_q + 3'd1;
                        if (rcnt_q == LAST_NIB) begin
                            state_d = LOAD;
                            done_d  = 1'b1;
                        end
                    end
                end

                default: begin
                    state_d = LOAD;
                end
            endcase
        end

        pcpi_valid_d = (state_d == ISSUE);
    end

    assign nib_ready      = (state_q == LOAD);
    assign res_valid      = (state_q == DRAIN);
    assign busy           = (state_q != LOAD);
    assign res_nib        = rd_q[{rcnt_q, 2'b00} +: NIB_W];
    assign bus.pcpi_valid = pcpi_valid_q;
    assign bus.pcpi_insn  = insn_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_pcpi_nibble_sequencer.sv
// Directed bench for pcpi_nibble_sequencer with a transaction-level model
// compared against the DUT on every falling edge outside reset.
module tb_pcpi_nibble_sequencer;
    import pcpi_seq_pkg::*;

    localparam int unsigned TO = 16;
    localparam int M_LOAD  = 0;
    localparam int M_ISSUE = 1;
    localparam int M_DRAIN = 2;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       flush     = 1'b0;
    logic       nib_valid = 1'b0;
    logic [3:0] nib_data  = 4'h0;
    logic       res_ack   = 1'b0;
    logic       nib_ready;
    logic       res_valid;
    logic [3:0] res_nib;
    logic       busy;
    logic       done;
    logic       err;

    pcpi_nibble_sequencer_if bus();

    pcpi_nibble_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .nib_valid (nib_valid),
        .nib_data  (nib_data),
        .nib_ready (nib_ready),
        .res_valid (res_valid),
        .res_nib   (res_nib),
        .res_ack   (res_ack),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: mode, how many nibbles loaded, how long
    // valid has been up, how many result nibbles consumed.
    int          m_mode;
    int          m_nibs;
    int          m_age;
    int          m_taken;
    bit          m_waited;
    bit          m_err;
    bit          m_done;
    logic [31:0] m_insn;
    logic [31:0] m_rd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode   <= M_LOAD;
            m_nibs   <= 0;
            m_age    <= 0;
            m_taken  <= 0;
            m_waited <= 1'b0;
            m_err    <= 1'b0;
            m_done   <= 1'b0;
            m_insn   <= 32'h0;
            m_rd     <= 32'h0;
        end else begin
            m_done <= 1'b0;
            if (flush) begin
                m_mode   <= M_LOAD;
                m_nibs   <= 0;
                m_age    <= 0;
                m_taken  <= 0;
                m_waited <= 1'b0;
                m_err    <= 1'b0;
            end else if (m_mode == M_LOAD) begin
                if (nib_valid) begin
                    m_insn <= (m_insn & ~(32'hF << (4 * m_nibs))) | (32'(nib_data) << (4 * m_nibs));
                    if (m_nibs == 0) m_err <= 1'b0;
                    if (m_nibs == 7) begin
                        m_nibs   <= 0;
                        m_mode   <= M_ISSUE;
                        m_age    <= 0;
                        m_waited <= 1'b0;
                    end else begin
                        m_nibs <= m_nibs + 1;
                    end
                end
            end else if (m_mode == M_ISSUE) begin
                m_age <= m_age + 1;
                if (bus.pcpi_wait) m_waited <= 1'b1;
                if (bus.pcpi_ready) begin
                    m_waited <= 1'b0;
                    if (bus.pcpi_wr) begin
                        m_rd    <= bus.pcpi_rd;
                        m_taken <= 0;
                        m_mode  <= M_DRAIN;
                    end else begin
                        m_mode <= M_LOAD;
                        m_done <= 1'b1;
                    end
                end else if (!m_waited && !bus.pcpi_wait && (m_age + 1) == TO) begin
                    // valid has now been up TO cycles without any sign of life
                    m_mode <= M_LOAD;
                    m_err  <= 1'b1;
                end
            end else begin
                if (res_ack) begin
                    if (m_taken == 7) begin
                        m_taken <= 0;
                        m_mode  <= M_LOAD;
                        m_done  <= 1'b1;
                    end else begin
                        m_taken <= m_taken + 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("nib_ready",  32'(nib_ready),      32'(m_mode == M_LOAD));
            check("busy",       32'(busy),           32'(m_mode != M_LOAD));
            check("res_valid",  32'(res_valid),      32'(m_mode == M_DRAIN));
            check("pcpi_valid", 32'(bus.pcpi_valid), 32'(m_mode == M_ISSUE));
            check("pcpi_insn",  bus.pcpi_insn,       m_insn);
            check("res_nib",    32'(res_nib),        (m_rd >> (4 * m_taken)) & 32'hF);
            check("done",       32'(done),           32'(m_done));
            check("err",        32'(err),            32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_nibs(input logic [31:0] w, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            nib_valid = 1'b1;
            nib_data  = w[4*i +: 4];
            tick();
        end
        nib_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_nib_ready"},  32'(nib_ready),      32'd1);
        check({tag, "_busy"},       32'(busy),           32'd0);
        check({tag, "_res_valid"},  32'(res_valid),      32'd0);
        check({tag, "_pcpi_valid"}, 32'(bus.pcpi_valid), 32'd0);
        check({tag, "_done"},       32'(done),           32'd0);
        check({tag, "_err"},        32'(err),            32'd0);
        check({tag, "_insn"},       bus.pcpi_insn,       32'h0);
    endtask

    logic [3:0] got[8];
    logic [3:0] exp1[8];
    int vcnt;
    int guard;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got running want finished");
        $fatal(1);
    end

    initial begin
        bus.pcpi_wr    = 1'b0;
        bus.pcpi_ready = 1'b0;
        bus.pcpi_wait  = 1'b0;
        bus.pcpi_rd    = 32'h0;
        exp1 = '{4'hD, 4'h0, 4'h0, 4'hF, 4'hE, 4'hF, 4'hA, 4'hC};

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // T1: load 1..8, ready+wr in ISSUE cycle 3, drain back-to-back.
        load_nibs(32'h87654321, 0, 8);
        check("t1_insn", bus.pcpi_insn, 32'h87654321);
        vcnt = 0;
        for (int c = 1; c <= 3; c++) begin
            if (bus.pcpi_valid) vcnt++;
            if (c == 3) begin
                bus.pcpi_ready = 1'b1;
                bus.pcpi_wr    = 1'b1;
                bus.pcpi_rd    = 32'hCAFEF00D;
            end
            tick();
        end
        bus.pcpi_ready = 1'b0;
        bus.pcpi_wr    = 1'b0;
        check("t1_valid_cycles", 32'(vcnt), 32'd3);
        check("t1_valid_low", 32'(bus.pcpi_valid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            got[k]  = res_nib;
            res_ack = 1'b1;
            tick();
        end
        res_ack = 1'b0;
        check("t1_done", 32'(done), 32'd1);
        check("t1_nib_ready", 32'(nib_ready), 32'd1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t1_res_nib%0d", k), 32'(got[k]), 32'(exp1[k]));
        end
        tick();
        check("t1_done_clear", 32'(done), 32'd0);

        // T2: no response -> timeout after exactly TO valid cycles.
        load_nibs(32'h13572468, 0, 8);
        vcnt  = 0;
        guard = 0;
        while (bus.pcpi_valid && guard < 100) begin
            vcnt++;
            guard++;
            tick();
        end
        check("t2_valid_cycles", 32'(vcnt), 32'd16);
        check("t2_err", 32'(err), 32'd1);
        check("t2_done", 32'(done), 32'd0);
        check("t2_nib_ready", 32'(nib_ready), 32'd1);
        load_nibs(32'hFEDCBA98, 0, 1);
        check("t2_err_cleared", 32'(err), 32'd0);
        load_nibs(32'hFEDCBA98, 1, 7);

        // T3: wait in cycle 2, ready (wr=0) in cycle 40.
        check("t3_insn", bus.pcpi_insn, 32'hFEDCBA98);
        vcnt = 0;
        for (int c = 1; c <= 40; c++) begin
            if (bus.pcpi_valid) vcnt++;
            bus.pcpi_wait  = (c == 2);
            bus.pcpi_ready = (c == 40);
            bus.pcpi_wr    = 1'b0;
            tick();
        end
        bus.pcpi_wait  = 1'b0;
        bus.pcpi_ready = 1'b0;
        check("t3_valid_cycles", 32'(vcnt), 32'd40);
        check("t3_done", 32'(done), 32'd1);
        check("t3_res_valid", 32'(res_valid), 32'd0);
        check("t3_err", 32'(err), 32'd0);

        // T4: ready coincides with the timeout cycle -> ready wins.
        load_nibs(32'hA5A50F0F, 0, 8);
        vcnt = 0;
        for (int c = 1; c <= 16; c++) begin
            if (bus.pcpi_valid) vcnt++;
            if (c == 16) begin
                bus.pcpi_ready = 1'b1;
                bus.pcpi_wr    = 1'b1;
                bus.pcpi_rd    = 32'h13579BDF;
            end
            tick();
        end
        bus.pcpi_ready = 1'b0;
        bus.pcpi_wr    = 1'b0;
        check("t4_valid_cycles", 32'(vcnt), 32'd16);
        check("t4_err", 32'(err), 32'd0);
        check("t4_res_valid", 32'(res_valid), 32'd1);
        check("t4_first_nib", 32'(res_nib), 32'hF);
        for (int k = 0; k < 8; k++) begin
            res_ack = 1'b1;
            tick();
            res_ack = 1'b0;
            if (k == 7) check("t4_done", 32'(done), 32'd1);
            tick();
        end

        // T5: flush mid-load and mid-drain.
        load_nibs(32'hDEADBEEF, 0, 5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_flush1_ready", 32'(nib_ready), 32'd1);
        check("t5_flush1_done", 32'(done), 32'd0);
        load_nibs(32'h0BADC0DE, 0, 8);
        check("t5_insn", bus.pcpi_insn, 32'h0BADC0DE);
        bus.pcpi_ready = 1'b1;
        bus.pcpi_wr    = 1'b1;
        bus.pcpi_rd    = 32'h76543210;
        tick();
        bus.pcpi_ready = 1'b0;
        bus.pcpi_wr    = 1'b0;
        res_ack = 1'b1;
        repeat (3) tick();
        res_ack = 1'b0;
        check("t5_rcnt3_nib", 32'(res_nib), 32'h3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_flush2_res_valid", 32'(res_valid), 32'd0);
        check("t5_flush2_ready", 32'(nib_ready), 32'd1);
        check("t5_flush2_done", 32'(done), 32'd0);
        tick();
        check("t5_flush2_done_late", 32'(done), 32'd0);

        // T6: asynchronous reset in the middle of ISSUE.
        load_nibs(32'h11223344, 0, 8);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        repeat (3) begin
            res_ack = 1'b1;
            tick();
            res_ack = 1'b0;
            tick();
        end
        check("t6_ack_ignored_ready", 32'(nib_ready), 32'd1);
        check("t6_ack_ignored_res_valid", 32'(res_valid), 32'd0);
        check("t6_ack_ignored_busy", 32'(busy), 32'd0);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
